// File: rtl/status_sender_if.sv
// status_sender_if: proto245 TX FIFO write port (sender is master, FIFO is slave)
interface status_sender_if #(parameter int DATA_W = 8);
  logic              txfifo_wr;
  logic [DATA_W-1:0] txfifo_data;
  logic              txfifo_full;
  modport master (output txfifo_wr, txfifo_data, input txfifo_full);
  modport slave  (input txfifo_wr, txfifo_data, output txfifo_full);
endinterface

// File: rtl/status_sender.sv
// status_sender: builds the status frame and streams it byte-wise into the proto245 TX FIFO.
// Define STATUS_SENDER_CHECKSUM_EN to append an XOR checksum byte.
module status_sender #(
  parameter int               NUM_CHANNELS = 128,
  parameter int               DATA_W       = 8,
  parameter int               CLK_CNT_W    = 8,
  parameter logic [DATA_W-1:0] HEADER      = 8'hA5,
  parameter int               ERR_CNT_W    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              status_req,
  input  logic                              read_error,
  input  logic                              err_clr,
  input  logic [CLK_CNT_W*NUM_CHANNELS-1:0] phases,
  status_sender_if.master                   tx,
  output logic                              busy
);
  localparam int IDX_W = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  typedef enum logic [2:0] {IDLE, HDR, NCH, ERRH, ERRL, PH, CSUM} state_t;
`ifdef STATUS_SENDER_CHECKSUM_EN
  localparam state_t PH_END = CSUM;
  logic [DATA_W-1:0] csum;
`else
  localparam state_t PH_END = IDLE;
`endif
  state_t                            state, state_n;
  logic [IDX_W-1:0]                  idx, idx_n;
  logic [DATA_W-1:0]                 data_q, data_n, tail;
  logic [CLK_CNT_W*NUM_CHANNELS-1:0] ph_snap;
  logic [ERR_CNT_W-1:0]              err_cnt, err_snap;
  logic [15:0]                       err_b;
  logic                              pending, re_q, accept, last, adv;
  assign accept         = state == IDLE && (status_req || pending);
  assign tx.txfifo_wr   = state != IDLE && !tx.txfifo_full;
  assign tx.txfifo_data = data_q;
  assign busy           = state != IDLE;
  assign adv            = accept || tx.txfifo_wr;
  assign last           = idx == IDX_W'(NUM_CHANNELS - 1);
  assign err_b          = 16'(err_snap);
`ifdef STATUS_SENDER_CHECKSUM_EN
  assign tail = csum ^ data_q;
`else
  assign tail = data_q;
`endif
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE:    state_n = accept ? HDR : IDLE;
      HDR:     state_n = NCH;
      NCH:     state_n = ERRH;
      ERRH:    state_n = ERRL;
      ERRL:    begin state_n = PH; idx_n = '0; end
      PH:      begin state_n = last ? PH_END : PH; idx_n = last ? idx : idx + 1'b1; end
      default: state_n = IDLE;
    endcase
    data_n = state_n == HDR  ? HEADER :
             state_n == NCH  ? DATA_W'(8'(NUM_CHANNELS)) :
             state_n == ERRH ? err_b[15:8] :
             state_n == ERRL ? err_b[7:0] :
             state_n == PH   ? DATA_W'(ph_snap[idx_n*CLK_CNT_W +: CLK_CNT_W]) : tail;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      data_q   <= '0;
      pending  <= 1'b0;
      re_q     <= 1'b0;
      err_cnt  <= '0;
      err_snap <= '0;
      ph_snap  <= '0;
`ifdef STATUS_SENDER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      re_q    <= read_error;
      err_cnt <= err_clr ? '0 : (read_error && !re_q && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
      pending <= accept ? 1'b0 : (state != IDLE && status_req) ? 1'b1 : pending;
      if (accept) begin
        ph_snap  <= phases;
        err_snap <= err_cnt;
      end
      if (adv) begin
        state  <= state_n;
        idx    <= idx_n;
        data_q <= data_n;
      end
`ifdef STATUS_SENDER_CHECKSUM_EN
      csum <= accept ? '0 : tx.txfifo_wr ? csum ^ data_q : csum;
`endif
    end
  end
endmodule

// File: tb/tb_status_sender.sv
// tb_status_sender: randomized scoreboard bench for status_sender with NUM_CHANNELS=4.
module tb_status_sender;
  localparam int N = 4;
`ifdef STATUS_SENDER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int FLEN = N + 4 + CS;
  logic clk = 0, rst = 1, status_req = 0, read_error = 0, err_clr = 0;
  logic force_full = 0, rnd_full = 0, rand_full = 0, busy;
  logic [8*N-1:0] phases;
  logic [7:0] ph [N];
  logic [7:0] exp_q [$];
  logic [15:0] m_err = 0;
  int n_cmp = 0, n_bad = 0, wr_seen = 0;
  status_sender_if #(.DATA_W(8)) tx();
  assign tx.txfifo_full = force_full | rnd_full;
  status_sender #(.NUM_CHANNELS(N)) dut (
    .clk(clk), .rst(rst), .status_req(status_req), .read_error(read_error),
    .err_clr(err_clr), .phases(phases), .tx(tx), .busy(busy));
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) phases[i*8 +: 8] = ph[i];
  always @(posedge clk) begin
    #1 rnd_full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
  end
  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  // scoreboard monitor: every FIFO write must match the next expected byte
  always @(negedge clk) begin
    if (tx.txfifo_full) check("wr_while_full", int'(tx.txfifo_wr), 0);
    if (tx.txfifo_wr) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got %0h expected no write at %0t", tx.txfifo_data, $time);
      end else check("frame_byte", int'(tx.txfifo_data), int'(exp_q.pop_front()));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_frame();
    logic [7:0] f [$];
    logic [7:0] x = 0;
    f = {8'hA5, 8'(N), m_err[15:8], m_err[7:0]};
    for (int i = 0; i < N; i++) f.push_back(ph[i]);
    foreach (f[i]) x ^= f[i];
    if (CS == 1) f.push_back(x);
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask
  task automatic req_pulse();
    status_req = 1;
    tick();
    status_req = 0;
  endtask
  task automatic request();
    push_frame();
    req_pulse();
  endtask
  task automatic pulse_err();
    read_error = 1;
    repeat (5) tick();
    read_error = 0;
    repeat (2) tick();
    m_err = m_err == 16'hFFFF ? m_err : m_err + 1;
  endtask
  task automatic clr_err();
    err_clr = 1;
    tick();
    err_clr = 0;
    m_err = 0;
  endtask
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d bytes left expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
    check("busy_after_frame", int'(busy), 0);
  endtask
  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
  initial begin
    int bc, w0, t;
    ph = '{8'h10, 8'h20, 8'h30, 8'h40};
    repeat (3) tick();
    check("rst_wr", int'(tx.txfifo_wr), 0);
    check("rst_data", int'(tx.txfifo_data), 0);
    check("rst_busy", int'(busy), 0);
    rst = 0;
    repeat (2) tick();
    // basic frame: latency, length and busy duration
    w0 = wr_seen;
    request();
    check("hdr_latency_wr", int'(tx.txfifo_wr), 1);
    check("hdr_latency_data", int'(tx.txfifo_data), 8'hA5);
    bc = 1;
    while (busy && bc < 100) begin
      tick();
      if (busy) bc++;
    end
    check("busy_cycles", bc, FLEN);
    check("frame_writes", wr_seen - w0, FLEN);
    drain();
    // FIFO full for 3 cycles on the third byte
    request();
    tick();
    tick();
    force_full = 1;
    repeat (3) begin
      check("held_data", int'(tx.txfifo_data), int'(exp_q[0]));
      tick();
    end
    force_full = 0;
    drain();
    // error counter: three edges, then clear coincident with a fourth edge
    repeat (3) pulse_err();
    request();
    drain();
    read_error = 1;
    clr_err();
    repeat (4) tick();
    read_error = 0;
    repeat (2) tick();
    request();
    drain();
    // requests while busy collapse into one extra frame with phases seen at its acceptance
    request();
    tick();
    ph = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_frame();
    req_pulse();
    req_pulse();
    req_pulse();
    drain();
    repeat (20) tick();
    // reset mid-frame truncates, drops pending and clears the error counter
    pulse_err();
    w0 = wr_seen;
    request();
    tick();
    req_pulse();
    t = 0;
    while (wr_seen < w0 + 5 && t < 50) begin
      tick();
      t++;
    end
    check("five_writes_seen", int'(wr_seen >= w0 + 5), 1);
    rst = 1;
    tick();
    exp_q.delete();
    m_err = 0;
    check("rst_mid_wr", int'(tx.txfifo_wr), 0);
    check("rst_mid_busy", int'(busy), 0);
    rst = 0;
    repeat (10) tick();
    check("no_pending_after_rst", int'(busy), 0);
    request();
    drain();
    // randomized frames with random FIFO backpressure and error activity
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) ph[i] = 8'($urandom);
      rand_full = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) pulse_err();
      if ($urandom_range(0, 3) == 0) clr_err();
      request();
      if ($urandom_range(0, 1) == 1) begin
        push_frame();
        req_pulse();
      end
      drain();
    end
    rand_full = 0;
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
